// File: rtl/tt_sai_decode_arbiter.sv
// Two-requester round-robin front end sharing one Hamming(7,4) SEC decoder,
// with a one-deep valid/ready output slot and saturating per-requester error counters.
module tt_sai_decode_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_valid,
    input  logic [6:0]       in_code0,
    input  logic [6:0]       in_code1,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syn,
    output logic             out_err,
    output logic             out_src,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1
);

    logic       slot_free;
    logic       last_src;
    logic [1:0] grant;
    logic [6:0] code;
    logic [2:0] syn;
    logic [3:0] data;

    assign slot_free = !out_valid || out_ready;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        grant = 2'b00;
        if (!rst && slot_free) begin
            unique case (in_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_src ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign in_ready = grant;

    always_comb begin
        code = grant[1] ? in_code1 : in_code0;
        syn  = {code[3] ^ code[4] ^ code[5] ^ code[6],
                code[1] ^ code[2] ^ code[5] ^ code[6],
                code[0] ^ code[2] ^ code[4] ^ code[6]};
        // Syndromes 1/2/4 point at parity bits, so the data nibble is left alone.
        data = {code[6] ^ (syn == 3'd7),
                code[5] ^ (syn == 3'd6),
                code[4] ^ (syn == 3'd5),
                code[2] ^ (syn == 3'd3)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_syn   <= 3'd0;
            out_err   <= 1'b0;
            out_src   <= 1'b0;
            last_src  <= 1'b1;
        end else if (grant != 2'b00) begin
            out_valid <= 1'b1;
            out_data  <= data;
            out_syn   <= syn;
            out_err   <= (syn != 3'd0);
            out_src   <= grant[1];
            last_src  <= grant[1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (grant != 2'b00 && syn != 3'd0) begin
            if (grant[0] && err_cnt0 != '1) err_cnt0 <= err_cnt0 + 1'b1;
            if (grant[1] && err_cnt1 != '1) err_cnt1 <= err_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_tt_sai_decode_arbiter.sv
// Scoreboard bench for tt_sai_decode_arbiter (CNT_W=2 so saturation is reachable).
module tb_tt_sai_decode_arbiter;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    in_valid = 2'b00;
    logic [6:0]    in_code0 = 7'h00;
    logic [6:0]    in_code1 = 7'h00;
    logic [1:0]    in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_data;
    logic [2:0]    out_syn;
    logic          out_err;
    logic          out_src;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] err_cnt0;
    logic [CW-1:0] err_cnt1;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] s;
        logic       e;
        logic       src;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    tt_sai_decode_arbiter #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code0(in_code0), .in_code1(in_code1),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_syn(out_syn), .out_err(out_err), .out_src(out_src), .clr_cnt(clr_cnt),
        .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
    );

    always #5 clk = ~clk;

    // Monitor: a word is consumed at the next posedge when valid && ready at negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL slot_unexpected: got data=%h syn=%0d src=%0d, expected no word",
                         out_data, out_syn, out_src);
            end else begin
                e = q.pop_front();
                if ({out_data, out_syn, out_err, out_src} !== e) begin
                    bad++;
                    $display("FAIL slot_word: got d=%h s=%0d e=%0d src=%0d, expected d=%h s=%0d e=%0d src=%0d",
                             out_data, out_syn, out_err, out_src, e.d, e.s, e.e, e.src);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus: drive, check in_ready mid-cycle, queue the word it grants.
    task automatic step(input logic r, input logic [1:0] v, input logic [6:0] c0,
                        input logic [6:0] c1, input logic ordy, input logic clr,
                        input logic [1:0] er, input logic [3:0] ed, input logic [2:0] es);
        #1;
        rst = r; in_valid = v; in_code0 = c0; in_code1 = c1; out_ready = ordy; clr_cnt = clr;
        @(negedge clk);
        chk("in_ready", {30'd0, in_ready}, {30'd0, er});
        if (er != 2'b00) q.push_back({ed, es, (es != 3'd0), er[1]});
        @(posedge clk);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b0, 2'b00, 4'h0, 3'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset: in_ready held low even with both requesters valid.
        step(1'b1, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b00, 4'h0, 3'd0);
        step(1'b1, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b00, 4'h0, 3'd0);
        #1;
        chk("reset_slot", {24'd0, out_valid, out_data, out_syn, out_err, out_src}, 32'd0);
        chk("reset_cnt", {28'd0, err_cnt0, err_cnt1}, 32'd0);

        // Clean word from requester 0.
        step(1'b0, 2'b01, 7'h55, 7'h00, 1'b1, 1'b0, 2'b01, 4'hB, 3'd0);
        idle();
        #1;
        chk("clean_cnt", {28'd0, err_cnt0, err_cnt1}, 32'd0);

        // Requester 1: data-bit error then parity-bit error.
        step(1'b0, 2'b10, 7'h00, 7'h45, 1'b1, 1'b0, 2'b10, 4'hB, 3'd5);
        #1;
        chk("err_cnt1_first", {30'd0, err_cnt1}, 32'd1);
        step(1'b0, 2'b10, 7'h00, 7'h54, 1'b1, 1'b0, 2'b10, 4'hB, 3'd1);
        idle();
        #1;
        chk("err_cnt1_second", {30'd0, err_cnt1}, 32'd2);

        // Both valid for 4 cycles: strict alternation, one word per cycle.
        step(1'b0, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b01, 4'hB, 3'd0);
        step(1'b0, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b10, 4'hF, 3'd0);
        step(1'b0, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b01, 4'hB, 3'd0);
        step(1'b0, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b10, 4'hF, 3'd0);
        idle();

        // Backpressure: slot holds, no grants, then drain and reload in the same cycle.
        step(1'b0, 2'b01, 7'h40, 7'h00, 1'b0, 1'b0, 2'b01, 4'h0, 3'd7);
        step(1'b0, 2'b01, 7'h55, 7'h00, 1'b0, 1'b0, 2'b00, 4'h0, 3'd0);
        #1;
        chk("stall_hold", {24'd0, out_valid, out_data, out_syn}, {24'd0, 1'b1, 4'h0, 3'd7});
        step(1'b0, 2'b01, 7'h55, 7'h00, 1'b0, 1'b0, 2'b00, 4'h0, 3'd0);
        step(1'b0, 2'b01, 7'h55, 7'h00, 1'b1, 1'b0, 2'b01, 4'hB, 3'd0);
        #1;
        chk("reload_word", {24'd0, out_valid, out_data, out_syn}, {24'd0, 1'b1, 4'hB, 3'd0});
        idle();
        #1;
        chk("stall_cnt0", {30'd0, err_cnt0}, 32'd1);

        // Saturation: 5 more errored words on requester 0 (1+5 would wrap to 2).
        for (int i = 0; i < 5; i++)
            step(1'b0, 2'b01, 7'h40, 7'h00, 1'b1, 1'b0, 2'b01, 4'h0, 3'd7);
        #1;
        chk("sat_cnt", {28'd0, err_cnt0, err_cnt1}, {28'd0, 2'd3, 2'd2});
        step(1'b0, 2'b01, 7'h40, 7'h00, 1'b1, 1'b1, 2'b01, 4'h0, 3'd7);
        #1;
        chk("clr_priority", {28'd0, err_cnt0, err_cnt1}, 32'd0);
        idle();

        // Reset while a word is stalled in the slot drops it.
        step(1'b0, 2'b01, 7'h40, 7'h00, 1'b0, 1'b0, 2'b01, 4'h0, 3'd7);
        #1;
        chk("pre_reset_cnt0", {30'd0, err_cnt0}, 32'd1);
        q.delete();
        step(1'b1, 2'b01, 7'h55, 7'h00, 1'b0, 1'b0, 2'b00, 4'h0, 3'd0);
        #1;
        chk("midreset_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_cnt", {28'd0, err_cnt0, err_cnt1}, 32'd0);

        // Pointer returns to its reset value: tie goes to requester 0 again.
        step(1'b0, 2'b11, 7'h55, 7'h7F, 1'b1, 1'b0, 2'b01, 4'hB, 3'd0);
        idle();
        idle();
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
